titan_bus_arbiter: RTL

Two-master, one-slave arbiter that shares the core's single memory bus between the instruction-fetch port (iport) and the load/store data port (dport).
- dport is driven by the decoder's mem_flags path.
- Policy: fixed priority to dport, with an anti-starvation limit for iport.
- A per-transaction timeout converts a hung slave into an error response.
- Sits between the core pipeline and the external Wishbone-style bus.

---
 rtl/titan_bus_arbiter_pkg.sv | 23 ++
 rtl/titan_bus_arbiter_timeout.sv | 32 +++
 rtl/titan_bus_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/titan_bus_arbiter_pkg.sv
// Shared definitions for the titan two-master bus arbiter: FSM state
// encodings, grant bit positions and default parameter values.
package titan_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  // Bit positions inside grant_o = {dport_owner, iport_owner}
  localparam int GNT_I_BIT = 0;
  localparam int GNT_D_BIT = 1;

  localparam int DEF_MAX_DBURST = 4;
  localparam int DEF_TIMEOUT    = 255;

  // Saturating increment for the 4-bit dport burst counter
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/titan_bus_arbiter_timeout.sv
// 8-bit transaction watchdog: cleared while no grant is held, counts
// grant cycles without a slave response, flags the last allowed cycle.
module titan_bus_arbiter_timeout
  import titan_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] cnt_o,
  output logic       expired_o
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  // Wait-cycle counter; clear has priority over counting
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign cnt_o     = r_cnt;
  assign expired_o = (r_cnt == LP_LAST);

endmodule

// File: rtl/titan_bus_arbiter.sv
// Two-master / one-slave arbiter sharing the memory bus between the
// instruction-fetch port (iport) and the load/store port (dport).
// dport has fixed priority, limited to MAX_DBURST consecutive grants while
// iport waits; a watchdog turns a silent slave into an error response.
module titan_bus_arbiter
  import titan_bus_arbiter_pkg::*;
#(
  parameter int MAX_DBURST = DEF_MAX_DBURST,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iport_addr_i,
  input  logic [31:0] iport_dat_i,
  input  logic [3:0]  iport_sel_i,
  input  logic        iport_we_i,
  input  logic        iport_cyc_i,
  input  logic        iport_stb_i,
  output logic [31:0] iport_dat_o,
  output logic        iport_ack_o,
  output logic        iport_err_o,
  input  logic [31:0] dport_addr_i,
  input  logic [31:0] dport_dat_i,
  input  logic [3:0]  dport_sel_i,
  input  logic        dport_we_i,
  input  logic        dport_cyc_i,
  input  logic        dport_stb_i,
  output logic [31:0] dport_dat_o,
  output logic        dport_ack_o,
  output logic        dport_err_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel_o,
  output logic        bus_we_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  output logic [1:0]  grant_o
);

  localparam logic [3:0] LP_MAXD = 4'(MAX_DBURST);

  arb_state_e  r_state;
  logic [3:0]  r_dcnt;

  logic        w_ireq;
  logic        w_dreq;
  logic        w_gnt;
  logic        w_own_i;
  logic        w_own_d;
  logic [31:0] w_own_addr;
  logic [31:0] w_own_dat;
  logic [3:0]  w_own_sel;
  logic        w_own_we;
  logic        w_own_cyc;
  logic        w_own_stb;
  logic        w_resp;
  logic        w_tmo_fire;
  logic        w_done;
  logic        w_ack;
  logic        w_err;
  logic [7:0]  w_tcnt;
  logic        w_tmo_expired;

  assign w_ireq  = iport_cyc_i & iport_stb_i;
  assign w_dreq  = dport_cyc_i & dport_stb_i;
  assign w_own_i = (r_state == ARB_GNT_I);
  assign w_own_d = (r_state == ARB_GNT_D);
  assign w_gnt   = w_own_i | w_own_d;
  assign w_resp  = bus_ack_i | bus_err_i;

  // Select the owner's request fields; everything reads zero when idle
  always_comb begin
    w_own_addr = '0;
    w_own_dat  = '0;
    w_own_sel  = '0;
    w_own_we   = 1'b0;
    w_own_cyc  = 1'b0;
    w_own_stb  = 1'b0;
    unique case (r_state)
      ARB_GNT_I: begin
        w_own_addr = iport_addr_i;
        w_own_dat  = iport_dat_i;
        w_own_sel  = iport_sel_i;
        w_own_we   = iport_we_i;
        w_own_cyc  = iport_cyc_i;
        w_own_stb  = iport_stb_i;
      end
      ARB_GNT_D: begin
        w_own_addr = dport_addr_i;
        w_own_dat  = dport_dat_i;
        w_own_sel  = dport_sel_i;
        w_own_we   = dport_we_i;
        w_own_cyc  = dport_cyc_i;
        w_own_stb  = dport_stb_i;
      end
      default: ;
    endcase
  end

  // Watchdog fires only on a live cycle with no slave response; an owner
  // abort (cyc dropped) ends the transaction silently instead.
  assign w_tmo_fire = w_gnt & w_own_cyc & ~w_resp & w_tmo_expired;
  assign w_done     = w_gnt & (~w_own_cyc | w_resp | w_tmo_fire);

  // Error wins over a simultaneous ack
  assign w_ack = w_gnt & bus_ack_i & ~bus_err_i;
  assign w_err = w_gnt & (bus_err_i | w_tmo_fire);

  assign bus_addr_o  = w_own_addr;
  assign bus_dat_o   = w_own_dat;
  assign bus_sel_o   = w_own_sel;
  assign bus_we_o    = w_own_we;
  assign bus_cyc_o   = w_own_cyc & ~w_tmo_fire;
  assign bus_stb_o   = w_own_cyc & w_own_stb & ~w_tmo_fire;

  assign iport_dat_o = w_gnt ? bus_dat_i : 32'd0;
  assign dport_dat_o = w_gnt ? bus_dat_i : 32'd0;
  assign iport_ack_o = w_own_i & w_ack;
  assign iport_err_o = w_own_i & w_err;
  assign dport_ack_o = w_own_d & w_ack;
  assign dport_err_o = w_own_d & w_err;

  assign grant_o[GNT_I_BIT] = w_own_i;
  assign grant_o[GNT_D_BIT] = w_own_d;

  // Arbitration FSM and dport burst counter; grants only leave from IDLE,
  // which guarantees one idle cycle between transactions
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ARB_IDLE;
      r_dcnt  <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_dreq && (!w_ireq || (r_dcnt != LP_MAXD))) begin
            r_state <= ARB_GNT_D;
            r_dcnt  <= w_ireq ? sat_inc4(r_dcnt) : 4'd0;
          end else if (w_ireq) begin
            r_state <= ARB_GNT_I;
            r_dcnt  <= '0;
          end
        end
        ARB_GNT_I, ARB_GNT_D: begin
          if (w_done) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  titan_bus_arbiter_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (~w_gnt),
    .en_i      (w_gnt & ~w_done),
    .cnt_o     (w_tcnt),
    .expired_o (w_tmo_expired)
  );

endmodule
